// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state enumeration and burst-length lookup
// used by the arbiter top and its round-robin picker.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ST_IDLE_OWN = 2'd0,
    ST_BURST    = 2'd1,
    ST_LOCKED   = 2'd2
  } arb_state_t;

  localparam int CNT_W = 4;

  // Beats remaining after the NONSEQ beat; zero for SINGLE/INCR (no fixed length).
  function automatic logic [CNT_W-1:0] burst_len_m1(input hburst_t b);
    logic [CNT_W-1:0] len;
    case (b)
      BURST_WRAP4,  BURST_INCR4:  len = 4'd3;
      BURST_WRAP8,  BURST_INCR8:  len = 4'd7;
      BURST_WRAP16, BURST_INCR16: len = 4'd15;
      default:                    len = 4'd0;
    endcase
    return len;
  endfunction

  function automatic logic is_fixed_burst(input hburst_t b);
    return burst_len_m1(b) != '0;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: searches req starting just after ptr and
// returns a one-hot winner, or master 0 when nobody requests.
module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int MASTER_NUM = 4
) (
  input  logic [MASTER_NUM-1:0]         req,
  input  logic [$clog2(MASTER_NUM)-1:0] ptr,
  output logic [MASTER_NUM-1:0]         gnt
);

  localparam int IDX_W = $clog2(MASTER_NUM);

  logic [IDX_W-1:0]        start;
  logic [2*MASTER_NUM-1:0] req_dbl;
  logic [MASTER_NUM-1:0]   req_rot;
  logic [MASTER_NUM-1:0]   gnt_rot;
  logic [2*MASTER_NUM-1:0] gnt_dbl;

  // Rotate so the search origin sits at bit 0, isolate the lowest set bit,
  // then rotate the winner back into master numbering.
  always_comb begin
    start   = (ptr == IDX_W'(MASTER_NUM - 1)) ? '0 : ptr + 1'b1;
    req_dbl = {req, req} >> start;
    req_rot = req_dbl[MASTER_NUM-1:0];
    gnt_rot = req_rot & (~req_rot + 1'b1);
    gnt_dbl = {gnt_rot, gnt_rot} << start;
    gnt     = gnt_dbl[2*MASTER_NUM-1:MASTER_NUM];
    if (req == '0) begin
      gnt = MASTER_NUM'(1);
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with fixed-burst tracking, locked
// transfers and a one-cycle HGRANT -> HMASTER address-phase handover.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int MASTER_NUM   = 4,
  parameter int HBURST_WIDTH = 3
) (
  input  logic                          HCLK,
  input  logic                          HRST,
  input  logic [MASTER_NUM-1:0]         HBUSREQ,
  input  logic [MASTER_NUM-1:0]         HLOCK,
  input  logic                          HREADY,
  input  logic [1:0]                    HTRANS,
  input  logic [HBURST_WIDTH-1:0]       HBURST,
  output logic [MASTER_NUM-1:0]         HGRANT,
  output logic [$clog2(MASTER_NUM)-1:0] HMASTER,
  output logic                          HMASTLOCK
);

  localparam int                    IDX_W         = $clog2(MASTER_NUM);
  localparam logic [MASTER_NUM-1:0] DEFAULT_GRANT = MASTER_NUM'(1);
  localparam logic [IDX_W-1:0]      LAST_RESET    = IDX_W'(MASTER_NUM - 1);

  arb_state_t            state_p1;
  logic [CNT_W-1:0]      cnt_p1;
  logic [IDX_W-1:0]      last_p1;

  htrans_t               trans;
  hburst_t               burst;
  logic [MASTER_NUM-1:0] rr_gnt;
  logic [IDX_W-1:0]      rr_idx;
  logic [IDX_W-1:0]      grant_idx;
  logic                  own_lock;
  logic                  any_req;
  logic                  start_burst;
  logic                  arb_point;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MASTER_NUM-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  ahb_rr_picker #(
    .MASTER_NUM (MASTER_NUM)
  ) u_picker (
    .req (HBUSREQ),
    .ptr (last_p1),
    .gnt (rr_gnt)
  );

  assign trans     = htrans_t'(HTRANS);
  assign burst     = hburst_t'(HBURST[2:0]);
  assign grant_idx = onehot_to_idx(HGRANT);
  assign rr_idx    = onehot_to_idx(rr_gnt);
  assign own_lock  = HLOCK[grant_idx];
  assign any_req   = |HBUSREQ;

  // A fixed burst ends on the SEQ that takes the counter from 1 to 0, so the
  // handover lands on the edge that completes the final beat.
  always_comb begin
    start_burst = 1'b0;
    arb_point   = 1'b0;
    case (state_p1)
      ST_IDLE_OWN: begin
        start_burst = (trans == TRANS_NONSEQ) && is_fixed_burst(burst);
        arb_point   = !start_burst;
      end
      ST_BURST: begin
        arb_point = (cnt_p1 == '0) ||
                    ((trans == TRANS_SEQ) && (cnt_p1 == CNT_W'(1)));
      end
      default: ;
    endcase
  end

  // Registered grant/ownership stage; everything freezes while HREADY is low.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      HGRANT    <= DEFAULT_GRANT;
      HMASTER   <= '0;
      HMASTLOCK <= 1'b0;
      state_p1  <= ST_IDLE_OWN;
      cnt_p1    <= '0;
      last_p1   <= LAST_RESET;
    end else if (HREADY) begin
      HMASTER   <= grant_idx;
      HMASTLOCK <= own_lock;
      if (state_p1 == ST_LOCKED) begin
        // Dropping HLOCK leaves the grant in place for one more transfer.
        if (!own_lock) state_p1 <= ST_IDLE_OWN;
      end else if (start_burst) begin
        state_p1 <= ST_BURST;
        cnt_p1   <= burst_len_m1(burst);
      end else if (arb_point) begin
        cnt_p1 <= '0;
        if (own_lock) begin
          state_p1 <= ST_LOCKED;
        end else begin
          state_p1 <= ST_IDLE_OWN;
          HGRANT   <= rr_gnt;
          if (any_req) last_p1 <= rr_idx;
        end
      end else if (trans == TRANS_SEQ) begin
        cnt_p1 <= cnt_p1 - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_ahb_arbiter;

  localparam int N = 4;

  logic         HCLK    = 1'b0;
  logic         HRST    = 1'b1;
  logic [N-1:0] HBUSREQ = '0;
  logic [N-1:0] HLOCK   = '0;
  logic         HREADY  = 1'b1;
  logic [1:0]   HTRANS  = 2'b00;
  logic [2:0]   HBURST  = 3'd0;
  logic [N-1:0] HGRANT;
  logic [1:0]   HMASTER;
  logic         HMASTLOCK;

  int checks   = 0;
  int failures = 0;

  ahb_arbiter #(
    .MASTER_NUM   (N),
    .HBURST_WIDTH (3)
  ) dut (
    .HCLK      (HCLK),
    .HRST      (HRST),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HREADY    (HREADY),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_g, m_last, m_master, m_left;
  bit m_mlock, m_locked;

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int burst_beats(input int b);
    return 4 << ((b - 2) / 2);
  endfunction

  task automatic m_arbitrate(input int owner);
    bit found;
    found = 0;
    if (bit_of(HLOCK, owner)) begin
      m_locked = 1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!found && bit_of(HBUSREQ, c)) begin
          m_g    = c;
          m_last = c;
          found  = 1;
        end
      end
      if (!found) m_g = 0;
    end
  endtask

  always @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      m_g = 0; m_last = N - 1; m_master = 0; m_mlock = 0; m_left = 0; m_locked = 0;
    end else if (HREADY) begin
      int owner;
      owner    = m_g;
      m_master = owner;
      m_mlock  = bit_of(HLOCK, owner);
      if (m_locked) begin
        if (!bit_of(HLOCK, owner)) m_locked = 0;
      end else if (m_left > 0) begin
        if (HTRANS == 2'b11) begin
          m_left--;
          if (m_left == 0) m_arbitrate(owner);
        end
      end else if (HTRANS == 2'b10 && HBURST >= 3'd2) begin
        m_left = burst_beats(int'(HBURST)) - 1;
      end else begin
        m_arbitrate(owner);
      end
    end
  end

  always @(negedge HCLK) begin
    if (!HRST) begin
      chk("model_grant", int'(HGRANT), 1 << m_g);
      chk("model_hmaster", int'(HMASTER), m_master);
      chk("model_hmastlock", int'(HMASTLOCK), int'(m_mlock));
      chk("grant_onehot", int'($onehot(HGRANT)), 1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [N-1:0] req, input logic [N-1:0] lk,
                      input logic rdy, input logic [1:0] tr, input logic [2:0] bu);
    HBUSREQ = req; HLOCK = lk; HREADY = rdy; HTRANS = tr; HBURST = bu;
    @(posedge HCLK); #1;
  endtask

  task automatic do_reset();
    HRST = 1'b1;
    HBUSREQ = '0; HLOCK = '0; HREADY = 1'b1; HTRANS = 2'b00; HBURST = 3'd0;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRST = 1'b0;
  endtask

  initial begin
    // Reset values and default master
    do_reset();
    chk("rst_grant", int'(HGRANT), 1);
    chk("rst_hmaster", int'(HMASTER), 0);
    chk("rst_hmastlock", int'(HMASTLOCK), 0);
    step(4'b0000, 4'b0000, 1, 2'b00, 3'd0);
    chk("idle_default_grant", int'(HGRANT), 1);
    chk("idle_default_hmaster", int'(HMASTER), 0);

    // Round-robin over all four requesters with SINGLE transfers
    do_reset();
    begin
      int exp_g[5] = '{1, 2, 4, 8, 1};
      int exp_m[5] = '{0, 0, 1, 2, 3};
      for (int i = 0; i < 5; i++) begin
        step(4'b1111, 4'b0000, 1, 2'b10, 3'd0);
        chk($sformatf("rr_grant_%0d", i), int'(HGRANT), exp_g[i]);
        chk($sformatf("rr_hmaster_%0d", i), int'(HMASTER), exp_m[i]);
      end
    end

    // INCR4 from master 1 is not truncated by other requests
    do_reset();
    step(4'b0010, 4'b0000, 1, 2'b00, 3'd0);
    chk("incr4_owner", int'(HGRANT), 2);
    step(4'b0101, 4'b0000, 1, 2'b10, 3'd3);
    chk("incr4_beat1", int'(HGRANT), 2);
    step(4'b0101, 4'b0000, 1, 2'b11, 3'd3);
    chk("incr4_beat2", int'(HGRANT), 2);
    step(4'b0101, 4'b0000, 1, 2'b11, 3'd3);
    chk("incr4_beat3", int'(HGRANT), 2);
    step(4'b0101, 4'b0000, 1, 2'b11, 3'd3);
    chk("incr4_handover", int'(HGRANT), 4);
    chk("incr4_hmaster", int'(HMASTER), 1);

    // INCR8 with a three-cycle wait state on beat 5 and a BUSY beat
    do_reset();
    step(4'b0010, 4'b0000, 1, 2'b00, 3'd0);
    step(4'b0101, 4'b0000, 1, 2'b10, 3'd5);
    for (int i = 0; i < 3; i++) step(4'b0101, 4'b0000, 1, 2'b11, 3'd5);
    for (int i = 0; i < 3; i++) begin
      step(4'b0101, 4'b0000, 0, 2'b11, 3'd5);
      chk($sformatf("incr8_wait_grant_%0d", i), int'(HGRANT), 2);
      chk($sformatf("incr8_wait_hmaster_%0d", i), int'(HMASTER), 1);
    end
    step(4'b0101, 4'b0000, 1, 2'b11, 3'd5);
    step(4'b0101, 4'b0000, 1, 2'b01, 3'd5);
    chk("incr8_busy", int'(HGRANT), 2);
    step(4'b0101, 4'b0000, 1, 2'b11, 3'd5);
    step(4'b0101, 4'b0000, 1, 2'b11, 3'd5);
    chk("incr8_beat7", int'(HGRANT), 2);
    step(4'b0101, 4'b0000, 1, 2'b11, 3'd5);
    chk("incr8_handover", int'(HGRANT), 4);

    // Master 2 holds a locked sequence, then one more transfer after HLOCK drops
    do_reset();
    step(4'b1111, 4'b0100, 1, 2'b10, 3'd0);
    step(4'b1111, 4'b0100, 1, 2'b10, 3'd0);
    step(4'b1111, 4'b0100, 1, 2'b10, 3'd0);
    chk("lock_reach_m2", int'(HGRANT), 4);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 4'b0100, 1, 2'b10, 3'd0);
      chk($sformatf("lock_grant_%0d", i), int'(HGRANT), 4);
      chk($sformatf("lock_mastlock_%0d", i), int'(HMASTLOCK), 1);
    end
    step(4'b1111, 4'b0000, 1, 2'b10, 3'd0);
    chk("unlock_extra_transfer", int'(HGRANT), 4);
    step(4'b1111, 4'b0000, 1, 2'b10, 3'd0);
    chk("unlock_handover", int'(HGRANT), 8);

    // Asynchronous reset in the middle of a burst
    do_reset();
    step(4'b0010, 4'b0000, 1, 2'b00, 3'd0);
    step(4'b0101, 4'b0000, 1, 2'b10, 3'd5);
    step(4'b0101, 4'b0000, 1, 2'b11, 3'd5);
    step(4'b0101, 4'b0000, 1, 2'b11, 3'd5);
    #2 HRST = 1'b1;
    #1;
    chk("async_rst_grant", int'(HGRANT), 1);
    chk("async_rst_hmaster", int'(HMASTER), 0);
    chk("async_rst_mastlock", int'(HMASTLOCK), 0);
    @(posedge HCLK); #1;
    HRST = 1'b0;
    step(4'b0010, 4'b0000, 0, 2'b00, 3'd0);
    chk("post_rst_wait", int'(HGRANT), 1);
    step(4'b0010, 4'b0000, 1, 2'b00, 3'd0);
    chk("post_rst_grant", int'(HGRANT), 2);

    // Randomized traffic with occasional resets; compare process checks the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        HRST = 1'b1;
        @(posedge HCLK); #1;
        HRST = 1'b0;
      end
      step(N'($urandom), N'($urandom & $urandom & $urandom),
           ($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom));
    end

    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
